// File: rtl/aes_round_scheduler_if.sv
// Control bundle between the AES round scheduler and its neighbours.
// The slave modport is the scheduler's view. The master modport is the view
// of the stream/key logic and the round core combined.
interface aes_round_scheduler_if;
  logic       key_valid;
  logic       key_ready;
  logic       key_load;
  logic       in_valid;
  logic       in_ready;
  logic       state_load;
  logic       key_restore;
  logic       round_en;
  logic [3:0] round_num;
  logic       last_round;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  modport slave (
    input  key_valid, in_valid, out_ready,
    output key_ready, key_load, in_ready, state_load, key_restore,
           round_en, round_num, last_round, out_valid, busy
  );

  modport master (
    output key_valid, in_valid, out_ready,
    input  key_ready, key_load, in_ready, state_load, key_restore,
           round_en, round_num, last_round, out_valid, busy
  );
endinterface

// File: rtl/aes_round_scheduler.sv
// aes_round_scheduler: control-only sequencer for an iterative AES-128 core.
// It takes a cipher key and then plaintext blocks. For each block it pulses
// round_en once per round, with round_num counting 1..NUM_ROUNDS. Each round
// lasts ROUND_LATENCY cycles. The finished block is then held as out_valid
// until the downstream handshake.
// Optional feature macro: AES_SCHED_BLOCK_CNT_EN adds the 32-bit block_cnt
// output. The count rises on each output handshake and is cleared on key_load.
module aes_round_scheduler #(
  parameter int NUM_ROUNDS    = 10,
  parameter int ROUND_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_round_scheduler_if.slave bus
`ifdef AES_SCHED_BLOCK_CNT_EN
  ,
  output logic [31:0]          block_cnt
`endif
);

  // Sequencer states
  localparam logic [2:0] S_WAIT_KEY = 3'd0;
  localparam logic [2:0] S_LOAD_KEY = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_ROUND    = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;

  // The in-round cycle counter stays at least 1 bit wide, even when ROUND_LATENCY is 1
  localparam int              CNT_W    = (ROUND_LATENCY > 1) ? $clog2(ROUND_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROUND_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       RND_LAST = 4'(NUM_ROUNDS);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [3:0]       r_round_num;
  logic [CNT_W-1:0] r_cnt;

  logic w_wait_key, w_load_key, w_idle, w_round, w_hold;
  logic w_out_hs, w_key_ready, w_in_ready, w_key_load, w_state_load;
  logic w_cnt_wrap, w_is_last;

  assign w_wait_key = (r_state == S_WAIT_KEY);
  assign w_load_key = (r_state == S_LOAD_KEY);
  assign w_idle     = (r_state == S_IDLE);
  assign w_round    = (r_state == S_ROUND);
  assign w_hold     = (r_state == S_HOLD);

  // The held block leaves when downstream takes it. That same cycle may also
  // accept the next block or a new key.
  assign w_out_hs    = w_hold & bus.out_ready;
  assign w_key_ready = w_wait_key | w_idle | w_out_hs;
  // A pending key always beats a pending block
  assign w_in_ready  = (w_idle | w_out_hs) & ~bus.key_valid;
  // Loads are suppressed while reset is asserted, so reset outputs stay clean
  assign w_key_load   = bus.key_valid & w_key_ready & ~rst;
  assign w_state_load = bus.in_valid & w_in_ready & ~rst;

  assign w_cnt_wrap = (r_cnt == CNT_LAST);
  assign w_is_last  = (r_round_num == RND_LAST);

  assign bus.key_ready   = w_key_ready;
  assign bus.in_ready    = w_in_ready;
  assign bus.key_load    = w_key_load;
  assign bus.state_load  = w_state_load;
  assign bus.key_restore = w_state_load;
  assign bus.round_en    = w_round & (r_cnt == '0);
  assign bus.round_num   = r_round_num;
  assign bus.last_round  = w_round & w_is_last;
  assign bus.out_valid   = w_hold;
  assign bus.busy        = w_load_key | w_round | w_hold;

  // Next-state selection
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_KEY: if (w_key_load) w_state_nxt = S_LOAD_KEY;
      S_LOAD_KEY: w_state_nxt = S_IDLE;
      S_IDLE: begin
        if (w_key_load)        w_state_nxt = S_LOAD_KEY;
        else if (w_state_load) w_state_nxt = S_ROUND;
      end
      S_ROUND: if (w_cnt_wrap && w_is_last) w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_state_load)       w_state_nxt = S_ROUND;
        else if (w_key_load)    w_state_nxt = S_LOAD_KEY;
        else if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_WAIT_KEY;
    endcase
  end

  // State register. Reset drops any block in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_WAIT_KEY;
    else     r_state <= w_state_nxt;
  end

  // Round index: 1 on block load, advanced at each round wrap, 0 once the last round ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_round_num <= 4'd0;
    end else if (w_state_load) begin
      r_round_num <= 4'd1;
    end else if (w_round && w_cnt_wrap) begin
      if (w_is_last) r_round_num <= 4'd0;
      else           r_round_num <= r_round_num + 4'd1;
    end
  end

  // Per-round cycle counter: runs 0..ROUND_LATENCY-1 only while in ROUND
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (w_state_load)          r_cnt <= '0;
    else if (w_round && !w_cnt_wrap) r_cnt <= r_cnt + CNT_ONE;
    else                            r_cnt <= '0;
  end

`ifdef AES_SCHED_BLOCK_CNT_EN
  logic [31:0] r_block_cnt;

  // Completed-block counter. A key load in the same cycle takes priority and clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_block_cnt <= 32'd0;
    else if (w_key_load) r_block_cnt <= 32'd0;
    else if (w_out_hs)   r_block_cnt <= r_block_cnt + 32'd1;
  end

  assign block_cnt = r_block_cnt;
`endif

endmodule

// File: doc/aes_round_scheduler.md
Name: aes_round_scheduler

Overview:
- Control-only sequencer for an iterative AES-128 encrypter: one shared round datapath and one on-the-fly key expander, both external.
- Accepts a cipher key and plaintext blocks via valid/ready handshakes. Drives load, round-enable and round-index controls into the datapath, then presents the finished block downstream.
- Sits between the stream/key interface logic and the round core. Carries no data, only control.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds after initial AddRoundKey (AES-128 = 10); legal range 1..14
ROUND_LATENCY, 1, clock cycles the datapath needs per round; legal range 1..8

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
key_valid  in  1  new cipher key presented
key_ready  out  1  scheduler accepts key this cycle
key_load  out  1  expander captures cipher key (equals key_valid & key_ready)
in_valid  in  1  plaintext block available
in_ready  out  1  scheduler accepts block this cycle
state_load  out  1  datapath captures plaintext XOR key0 (equals in_valid & in_ready)
key_restore  out  1  expander rewinds to round-0 key (equals state_load)
round_en  out  1  one-cycle pulse: datapath and expander start round round_num
round_num  out  4  current round index, 1..NUM_ROUNDS; 0 when not in a round
last_round  out  1  round_num == NUM_ROUNDS (datapath skips MixColumns)
out_valid  out  1  encrypted block held on datapath output
out_ready  in  1  downstream accepts block
busy  out  1  state is LOAD_KEY, ROUND or HOLD

Behaviour:
- Reset (async, any state, including mid-block): state=WAIT_KEY, round_num=0, cycle counter=0. Outputs: key_ready=1, in_ready=0, out_valid=0, round_en=0, last_round=0, busy=0, key_load=0, state_load=0, key_restore=0. A block in flight is discarded and no out_valid is produced for it.
- WAIT_KEY: key_ready=1, in_ready=0. On key handshake, pulse key_load and go to LOAD_KEY.
- LOAD_KEY: one cycle for the expander to settle; key_ready=0. Then go to IDLE.
- IDLE: key_ready=1, in_ready=1.
  - If key_valid and in_valid are both high in the same cycle, the key wins: in_ready is forced to 0 that cycle, key_load fires, go to LOAD_KEY.
  - Otherwise, a block handshake (edge T) pulses state_load and key_restore, sets round_num=1, and goes to ROUND.
- ROUND:
  - round_en=1 on the first cycle of each round only.
  - Counter runs 0..ROUND_LATENCY-1. At wrap: if round_num==NUM_ROUNDS, go to HOLD; else round_num++.
  - key_ready=0 and in_ready=0. Key changes are not possible mid-block.
- HOLD: out_valid=1, round_num=0.
  - in_ready = out_ready and not key_valid, so a back-to-back block can be accepted with zero bubble.
  - On out_ready: if a new block handshakes in the same cycle, go to ROUND with round_num=1; else if key_valid, key_ready=1, accept the key, go to LOAD_KEY; else go to IDLE.
  - key_ready = out_ready.
- Latency: first out_valid at T+1+NUM_ROUNDS*ROUND_LATENCY (defaults: T+11).
  - Sustained throughput: one block per NUM_ROUNDS*ROUND_LATENCY+1 cycles with out_ready tied high.
- out_valid, once set, stays high and the block is held until out_ready. No output is ever dropped.
- round_num is 4 bits. It never exceeds NUM_ROUNDS and never wraps.

Optional Feature:
AES_SCHED_BLOCK_CNT_EN
- Defined: adds output block_cnt [31:0].
  - Increments on each out_valid & out_ready. Wraps 0xFFFFFFFF->0.
  - Cleared by rst and on every key_load.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
1. Reset, key_valid=1 for 1 cycle, then in_valid=1 at T, out_ready=1 -> key_load 1 pulse; round_en pulses T+1..T+10 with round_num 1..10; last_round only at round 10; out_valid at T+11 for 1 cycle.
2. ROUND_LATENCY=3, one block, out_ready=0 until T+40 -> round_en every 3rd cycle; out_valid rises at T+31 and holds until the T+40 handshake.
3. in_valid held high, out_ready=1 -> blocks accepted at T, T+11, T+22; out_valid at T+11, T+22, T+33; no idle cycle between them.
4. key_valid and in_valid asserted together in IDLE -> key_load=1, state_load=0, in_ready=0; block accepted 2 cycles later.
5. key_valid=1 during ROUND at round 5 -> key_ready=0 until HOLD. Key accepted at the HOLD handshake, no new block taken that cycle, state goes to LOAD_KEY.
6. rst asserted at round 6 -> all outputs at reset values asynchronously; state WAIT_KEY; no out_valid. With AES_SCHED_BLOCK_CNT_EN defined: 3 blocks give block_cnt=3, and a following key_load gives block_cnt=0.
